// File: rtl/tdm_pkg.sv
// tdm_pkg -- shared definitions for the TDM demultiplexer.
//   tdm_state_e      : framing FSM states (HUNT searching for start of frame, SYNC locked)
//   TDM_N_CH_DEFAULT : default number of time-division channels per frame
//   TDM_W_DEFAULT    : default data word width in bits
package tdm_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    SYNC = 1'b1
  } tdm_state_e;

  localparam int TDM_N_CH_DEFAULT = 4;
  localparam int TDM_W_DEFAULT    = 8;

endpackage : tdm_pkg

// File: rtl/tdm_demux_onehot.sv
// demux_onehot -- combinational channel selector.
//   idx   in  : channel index to enable
//   wr_en in  : write strobe; when low no enable is asserted
//   en    out : N_CH-bit one-hot enable (all zero when wr_en is low)
module demux_onehot
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH_DEFAULT
) (
  input  logic [$clog2(N_CH)-1:0] idx,
  input  logic                    wr_en,
  output logic [N_CH-1:0]         en
);

  localparam int IW = $clog2(N_CH);

  // Decode the index into a one-hot enable, gated by the write strobe.
  always_comb begin
    en = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en && (idx == IW'(i))) begin
        en[i] = 1'b1;
      end else begin
        en[i] = 1'b0;
      end
    end
  end

endmodule : demux_onehot

// File: rtl/tdm_demux.sv
// tdm_demux -- time-division demultiplexer with start-of-frame framing.
//   clk        in  : single clock, rising edge
//   rst        in  : asynchronous active-high reset
//   in_valid   in  : a word is present on in_data
//   in_sof     in  : start of frame, marks the channel-0 word (qualified by in_valid)
//   in_data    in  : multiplexed data word
//   ch_data    out : per-channel registered data, held until that channel is rewritten
//   ch_valid   out : one-hot pulse marking the channel updated this cycle
//   frame_done out : pulse when the last channel of a frame is written
//   frame_err  out : pulse on any framing violation
//   locked     out : high while the framer is in SYNC
// All outputs come straight from flops; an accepted word appears one cycle later.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH_DEFAULT,
  parameter int W    = TDM_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [W-1:0]           in_data,
  output logic [N_CH-1:0][W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_valid,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   locked
);

  localparam int IW = $clog2(N_CH);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);

  tdm_state_e             state_q, state_d;
  logic [IW-1:0]          ch_idx_q, ch_idx_d;
  logic [N_CH-1:0][W-1:0] ch_data_q, ch_data_d;
  logic [N_CH-1:0]        ch_valid_q, ch_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   locked_q, locked_d;

  logic                   wr_s;
  logic [IW-1:0]          wr_idx_s;
  logic [N_CH-1:0]        wr_en_s;

  demux_onehot #(
    .N_CH (N_CH)
  ) u_sel (
    .idx   (wr_idx_s),
    .wr_en (wr_s),
    .en    (wr_en_s)
  );

  // Framing decisions: which channel (if any) takes the word, errors, next state.
  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    wr_s        = 1'b0;
    wr_idx_s    = ch_idx_q;
    frame_err_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sof) begin
            wr_s     = 1'b1;
            wr_idx_s = IDX_ZERO;
            ch_idx_d = IDX_ONE;
            state_d  = SYNC;
          end else begin
            // Not a frame start: silently discard while hunting.
            wr_s = 1'b0;
          end
        end
        SYNC: begin
          if (in_sof) begin
            // sof always realigns to channel 0; it is only an error mid-frame.
            wr_s        = 1'b1;
            wr_idx_s    = IDX_ZERO;
            ch_idx_d    = IDX_ONE;
            frame_err_d = (ch_idx_q != IDX_ZERO);
          end else if (ch_idx_q == IDX_ZERO) begin
            // Expected a frame start but none came: lose lock.
            frame_err_d = 1'b1;
            state_d     = HUNT;
            ch_idx_d    = IDX_ZERO;
          end else begin
            wr_s     = 1'b1;
            wr_idx_s = ch_idx_q;
            if (ch_idx_q == IDX_LAST) begin
              ch_idx_d = IDX_ZERO;
            end else begin
              ch_idx_d = ch_idx_q + IDX_ONE;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          ch_idx_d = IDX_ZERO;
        end
      endcase
    end else begin
      wr_s = 1'b0;
    end
  end

  // Output next-values derived from the one-hot channel enable.
  always_comb begin
    ch_data_d = ch_data_q;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en_s[i]) begin
        ch_data_d[i] = in_data;
      end else begin
        ch_data_d[i] = ch_data_q[i];
      end
    end
    ch_valid_d   = wr_en_s;
    frame_done_d = wr_en_s[N_CH-1];
    locked_d     = (state_d == SYNC);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      ch_idx_q     <= IDX_ZERO;
      ch_data_q    <= {(N_CH*W){1'b0}};
      ch_valid_q   <= {N_CH{1'b0}};
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      locked_q     <= locked_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign locked     = locked_q;

endmodule : tdm_demux

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux -- directed scenarios plus randomized traffic for tdm_demux,
// checked against a behavioural frame model kept in the bench.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_sof;
  logic [W-1:0]           in_data;
  logic [N_CH-1:0][W-1:0] ch_data;
  logic [N_CH-1:0]        ch_valid;
  logic                   frame_done;
  logic                   frame_err;
  logic                   locked;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;

  // Reference model: whether a frame is being tracked, which channel is next.
  logic [N_CH-1:0][W-1:0] m_data;
  bit                     m_sync;
  int                     m_next;
  logic [N_CH-1:0]        m_valid;
  logic                   m_done;
  logic                   m_err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_sync  = 1'b0;
    m_next  = 0;
    m_valid = '0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_write(input int c, input logic [W-1:0] d);
    m_data[c]  = d;
    m_valid    = '0;
    m_valid[c] = 1'b1;
    m_done     = (c == N_CH - 1);
  endtask

  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    m_valid = '0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (s) begin
        if (m_sync && m_next != 0) m_err = 1'b1;
        model_write(0, d);
        m_sync = 1'b1;
        m_next = 1;
      end else if (m_sync) begin
        if (m_next == 0) begin
          m_err  = 1'b1;
          m_sync = 1'b0;
        end else begin
          model_write(m_next, d);
          m_next = (m_next + 1) % N_CH;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ch_data"},    64'(ch_data),    64'(m_data));
    chk({tag, ".ch_valid"},   64'(ch_valid),   64'(m_valid));
    chk({tag, ".frame_done"}, 64'(frame_done), 64'(m_done));
    chk({tag, ".frame_err"},  64'(frame_err),  64'(m_err));
    chk({tag, ".locked"},     64'(locked),     64'(m_sync));
  endtask

  task automatic step(input string tag, input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    check_all(tag);
    if (frame_err) err_seen++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b0;
  endtask

  task automatic frame4(input string tag, input int max_gap);
    logic [W-1:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step(tag, 1'b1, (i == 0), words[i]);
      for (int g = 0; g < $urandom_range(0, max_gap); g++)
        step({tag, ".gap"}, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  initial begin
    logic [N_CH-1:0][W-1:0] snap;
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = 8'h00;
    model_reset();
    #2;

    // Reset state
    do_reset("reset");
    chk("reset.data_zero", 64'(ch_data), 64'h0);

    // Basic frame
    step("f1.w0", 1'b1, 1'b1, 8'h11);
    chk("f1.v0", 64'(ch_valid), 64'h1);
    step("f1.w1", 1'b1, 1'b0, 8'h22);
    chk("f1.v1", 64'(ch_valid), 64'h2);
    step("f1.w2", 1'b1, 1'b0, 8'h33);
    chk("f1.v2", 64'(ch_valid), 64'h4);
    step("f1.w3", 1'b1, 1'b0, 8'h44);
    chk("f1.v3", 64'(ch_valid), 64'h8);
    chk("f1.done", 64'(frame_done), 64'h1);
    chk("f1.data", 64'(ch_data), 64'h44332211);
    chk("f1.locked", 64'(locked), 64'h1);

    // Word without sof while hunting is dropped
    do_reset("r2");
    err_seen = 0;
    step("hunt.aa", 1'b1, 1'b0, 8'hAA);
    chk("hunt.aa_nowrite", 64'(ch_valid), 64'h0);
    frame4("hunt.frame", 0);
    chk("hunt.data", 64'(ch_data), 64'h44332211);
    chk("hunt.no_err", 64'(err_seen), 64'h0);

    // Mid-frame sof resync
    err_seen = 0;
    step("rs.w0", 1'b1, 1'b1, 8'h01);
    step("rs.w1", 1'b1, 1'b0, 8'h02);
    step("rs.sof", 1'b1, 1'b1, 8'h05);
    chk("rs.ch0", 64'(ch_data[0]), 64'h05);
    step("rs.next", 1'b1, 1'b0, 8'h0C);
    chk("rs.next_ch1", 64'(ch_valid), 64'h2);
    chk("rs.err_once", 64'(err_seen), 64'h1);
    step("rs.w2", 1'b1, 1'b0, 8'h0D);
    step("rs.w3", 1'b1, 1'b0, 8'h0E);

    // Missing sof after a full frame
    step("ms.w0", 1'b1, 1'b1, 8'hA1);
    step("ms.w1", 1'b1, 1'b0, 8'hA2);
    step("ms.w2", 1'b1, 1'b0, 8'hA3);
    step("ms.w3", 1'b1, 1'b0, 8'hA4);
    snap = ch_data;
    step("ms.77", 1'b1, 1'b0, 8'h77);
    chk("ms.err", 64'(frame_err), 64'h1);
    chk("ms.unlocked", 64'(locked), 64'h0);
    chk("ms.unchanged", 64'(ch_data), 64'(snap));

    // Frame with idle gaps
    frame4("gap", 3);
    chk("gap.data", 64'(ch_data), 64'h44332211);

    // Reset mid-frame
    step("rm.w0", 1'b1, 1'b1, 8'h5A);
    step("rm.w1", 1'b1, 1'b0, 8'h5B);
    do_reset("rm.rst");
    step("rm.99", 1'b1, 1'b0, 8'h99);
    chk("rm.99_dropped", 64'(ch_data), 64'h0);
    frame4("rm.frame", 1);
    chk("rm.data", 64'(ch_data), 64'h44332211);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tdm_demux

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of time-division channels per frame (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 8, giving the data word width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  a word is present on in_data this cycle.
REQ-006 in_sof  input  1  start of frame; qualified by in_valid and marks the channel-0 word.
REQ-007 in_data  input  W  multiplexed data word.
REQ-008 ch_data  output  [N_CH-1:0][W-1:0]  per-channel registered data; each entry holds its last value until that channel is rewritten.
REQ-009 ch_valid  output  N_CH  one-hot, one-cycle pulse marking the channel updated this cycle.
REQ-010 frame_done  output  1  one-cycle pulse when the channel N_CH-1 word is written.
REQ-011 frame_err  output  1  one-cycle pulse on any framing violation.
REQ-012 locked  output  1  high while the FSM is in state SYNC.

Function
REQ-013 The FSM SHALL have exactly two states: HUNT and SYNC.
REQ-014 The channel index ch_idx SHALL be $clog2(N_CH) bits wide and SHALL advance only on accepted words.
REQ-015 In HUNT, words with in_valid=1 and in_sof=0 SHALL be dropped with no output activity and no frame_err.
REQ-016 In HUNT, on in_valid=1 with in_sof=1, the word SHALL be written to channel 0; ch_idx SHALL become 1 and the state SHALL become SYNC.
REQ-017 In SYNC, each in_valid word SHALL be written to ch_data[ch_idx].
REQ-018 After each SYNC write, ch_idx SHALL increment, wrapping from N_CH-1 to 0.
REQ-019 Latency SHALL be 1 cycle: the input word is accepted at edge k, and ch_data and ch_valid reflect it after edge k.
REQ-020 frame_done SHALL pulse in the same cycle as ch_valid[N_CH-1].
REQ-021 In SYNC, if ch_idx==0 and the word arrives with in_valid=1 and in_sof=0, the block SHALL pulse frame_err, drop the word, and go to HUNT with ch_idx=0.
REQ-022 In SYNC, if ch_idx!=0 and the word arrives with in_valid=1 and in_sof=1, the block SHALL pulse frame_err, write the word to channel 0 (resync), set ch_idx=1, and stay in SYNC.
REQ-023 In SYNC, if ch_idx==0 and the word arrives with in_valid=1 and in_sof=1, the word SHALL be accepted normally.
REQ-024 When in_valid=0, all state and ch_data SHALL hold; ch_valid, frame_done and frame_err SHALL be 0.
REQ-025 in_sof SHALL be ignored when in_valid=0.
REQ-026 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-027 Reset SHALL force the state to HUNT and ch_idx to 0.
REQ-028 Reset SHALL clear all ch_data entries, ch_valid, frame_done, frame_err and locked to 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL require a new in_sof before writing any channel.
REQ-030 The first edge after reset release SHALL be a normal functional edge.

Structure
REQ-031 Package tdm_pkg SHALL hold the state enum (HUNT, SYNC) and the default constants for N_CH and W.
REQ-032 Channel selection SHALL use one sub-module, demux_onehot: combinational, index in, N_CH-bit one-hot enable out, gated by a write strobe.
REQ-033 The sub-module outputs SHALL drive both the ch_data write enables and ch_valid.
REQ-034 The implementation SHALL be a single clocked process plus the demux_onehot instance; no memories or FIFOs.

Verification (N_CH=4, W=8)
REQ-035 Scenario: reset, then a frame sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> ch_data = {0x44,0x33,0x22,0x11}; ch_valid = 0001, 0010, 0100, 1000; frame_done on the 4th output cycle; locked=1.
REQ-036 Scenario: 0xAA without sof while in HUNT, then a good frame -> 0xAA is never written; frame_err stays 0.
REQ-037 Scenario: frame sof+0x01, 0x02, then sof+0x05 -> frame_err pulses once; ch_data[0]=0x05; the next word goes to channel 1.
REQ-038 Scenario: a full frame, then 0x77 without sof -> frame_err pulses; locked=0; ch_data unchanged.
REQ-039 Scenario: frame words separated by random in_valid gaps -> results identical to REQ-035 with no spurious pulses.
REQ-040 Scenario: rst asserted after 2 words of a frame, then 0x99 without sof, then a good frame -> all outputs 0 during reset; 0x99 is dropped; the good frame is demultiplexed correctly.
